// File: rtl/rover_drive_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : rover_drive_sequencer
// Brief    : Drive controller for the line-following rover. Synchronises and
//            debounces the inductive line sensors and the proximity sensor,
//            sequences the H-bridge through FOLLOW / REVERSE / TURN / SEARCH /
//            STOP, and gates the motor enables with a PWM speed generator.
//            Optional feature macro: DRIVE_SOFTSTART_EN (ramps the effective
//            PWM duty from 0 on every entry into FOLLOW).
// Revision : 1.0 - initial release
// ============================================================================
module rover_drive_sequencer #(
    parameter int DEBOUNCE_CYC   = 16,
    parameter int PWM_BITS       = 8,
    parameter int AVOID_REV_CYC  = 1000,
    parameter int AVOID_TURN_CYC = 2000,
    parameter int LOST_CYC       = 5000,
    parameter int SEARCH_CYC     = 20000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                run,
    input  logic [2:0]          induct,
    input  logic                proxim,
    input  logic [PWM_BITS-1:0] duty,
    output logic [3:0]          motorIn,
    output logic [1:0]          motorEn,
    output logic [2:0]          state,
    output logic                lost
);

    // H-bridge direction codes
    localparam logic [3:0] c_DIR_FWD     = 4'b1001;
    localparam logic [3:0] c_DIR_STEER_L = 4'b0101;
    localparam logic [3:0] c_DIR_STEER_R = 4'b1010;
    localparam logic [3:0] c_DIR_REV     = 4'b0110;
    localparam logic [3:0] c_DIR_OFF     = 4'b0000;

    localparam int c_DB_W      = $clog2(DEBOUNCE_CYC + 1);
    localparam int c_LOST_W    = $clog2(LOST_CYC + 1);
    localparam int c_DWELL_MAX = (SEARCH_CYC > AVOID_TURN_CYC) ?
                                 ((SEARCH_CYC > AVOID_REV_CYC) ? SEARCH_CYC : AVOID_REV_CYC) :
                                 ((AVOID_TURN_CYC > AVOID_REV_CYC) ? AVOID_TURN_CYC : AVOID_REV_CYC);
    localparam int c_DWELL_W   = $clog2(c_DWELL_MAX + 1);

    typedef enum logic [2:0] {
        ST_STOP    = 3'd0,
        ST_FOLLOW  = 3'd1,
        ST_REVERSE = 3'd2,
        ST_TURN    = 3'd3,
        ST_SEARCH  = 3'd4
    } state_t;

    // Input synchronisers and debounce filters
    logic [2:0]          induct_s1_q, induct_s1_d, induct_s2_q, induct_s2_d;
    logic                proxim_s1_q, proxim_s1_d, proxim_s2_q, proxim_s2_d;
    logic [2:0]          fi_q, fi_d, fi_cand_q, fi_cand_d;
    logic                fp_q, fp_d, fp_cand_q, fp_cand_d;
    logic [c_DB_W-1:0]   fi_cnt_q, fi_cnt_d, fp_cnt_q, fp_cnt_d;
    logic [c_DB_W-1:0]   fi_run, fp_run;

    // Sequencer state
    state_t                state_q, state_d;
    logic [c_DWELL_W-1:0]  dwell_q, dwell_d;
    logic [c_LOST_W-1:0]   lost_cnt_q, lost_cnt_d;
    logic                  lost_q, lost_d;
    logic [3:0]            last_dir_q, last_dir_d;
    logic [3:0]            motor_in_q, motor_in_d;
    logic [1:0]            motor_en_q, motor_en_d;

    // PWM
    logic [PWM_BITS-1:0]   pwm_cnt_q, pwm_cnt_d;
    logic [PWM_BITS-1:0]   duty_cmp;
    logic                  pwm_on;
`ifdef DRIVE_SOFTSTART_EN
    logic [PWM_BITS-1:0]   eff_duty_q, eff_duty_d;
`endif

    // Line decode helpers
    logic       line_valid;
    logic [3:0] line_dir;
    logic [3:0] follow_dir;
    logic       off_tape;

    // Two-flop synchronisers feeding the debounce filters
    always_comb begin
        induct_s1_d = induct;
        induct_s2_d = induct_s1_q;
        proxim_s1_d = proxim;
        proxim_s2_d = proxim_s1_q;
    end

    // Debounce: filtered value follows the synced value only after it has held
    // one differing value for DEBOUNCE_CYC cycles; any change restarts the run.
    always_comb begin
        fi_d      = fi_q;
        fi_cnt_d  = '0;
        fi_cand_d = induct_s2_q;
        fi_run    = '0;
        if (induct_s2_q != fi_q) begin
            fi_run = (induct_s2_q == fi_cand_q) ? fi_cnt_q + 1'b1 : c_DB_W'(1);
            if (fi_run >= c_DB_W'(DEBOUNCE_CYC)) begin
                fi_d = induct_s2_q;
            end else begin
                fi_cnt_d = fi_run;
            end
        end

        fp_d      = fp_q;
        fp_cnt_d  = '0;
        fp_cand_d = proxim_s2_q;
        fp_run    = '0;
        if (proxim_s2_q != fp_q) begin
            fp_run = (proxim_s2_q == fp_cand_q) ? fp_cnt_q + 1'b1 : c_DB_W'(1);
            if (fp_run >= c_DB_W'(DEBOUNCE_CYC)) begin
                fp_d = proxim_s2_q;
            end else begin
                fp_cnt_d = fp_run;
            end
        end
    end

    // Line decode of the filtered sensors (active low: 0 means on tape)
    always_comb begin
        line_valid = 1'b1;
        line_dir   = c_DIR_FWD;
        case (fi_q)
            3'b101:          line_dir = c_DIR_FWD;
            3'b001, 3'b011:  line_dir = c_DIR_STEER_L;
            3'b100, 3'b110:  line_dir = c_DIR_STEER_R;
            default:         line_valid = 1'b0;   // 111 off-tape, 000/010 ambiguous
        endcase
        off_tape   = (fi_q == 3'b111);
        follow_dir = line_valid ? line_dir : last_dir_q;
        last_dir_d = follow_dir;
    end

    // Next-state logic; run=0 overrides every rule and releases the lost flag
    always_comb begin
        state_d    = state_q;
        lost_d     = lost_q;
        lost_cnt_d = '0;
        if (!run) begin
            state_d = ST_STOP;
            lost_d  = 1'b0;
        end else begin
            case (state_q)
                ST_STOP: begin
                    if (!lost_q) state_d = ST_FOLLOW;
                end
                ST_FOLLOW: begin
                    if (fp_q) begin
                        state_d = ST_REVERSE;
                    end else if (off_tape) begin
                        if (lost_cnt_q == c_LOST_W'(LOST_CYC - 1)) begin
                            state_d = ST_SEARCH;
                        end else begin
                            lost_cnt_d = lost_cnt_q + 1'b1;
                        end
                    end
                end
                ST_REVERSE: begin
                    if (dwell_q == c_DWELL_W'(AVOID_REV_CYC - 1)) state_d = ST_TURN;
                end
                ST_TURN: begin
                    if (fp_q) begin
                        state_d = ST_REVERSE;
                    end else if (dwell_q == c_DWELL_W'(AVOID_TURN_CYC - 1)) begin
                        state_d = off_tape ? ST_SEARCH : ST_FOLLOW;
                    end
                end
                ST_SEARCH: begin
                    if (fp_q) begin
                        state_d = ST_REVERSE;
                    end else if (!off_tape) begin
                        state_d = ST_FOLLOW;
                    end else if (dwell_q == c_DWELL_W'(SEARCH_CYC - 1)) begin
                        state_d = ST_STOP;
                        lost_d  = 1'b1;
                    end
                end
                default: state_d = ST_STOP;
            endcase
        end

        // Shared dwell timer: cleared on any state entry, saturates otherwise
        if (state_d != state_q) begin
            dwell_d = '0;
        end else if (dwell_q == c_DWELL_W'(c_DWELL_MAX)) begin
            dwell_d = dwell_q;
        end else begin
            dwell_d = dwell_q + 1'b1;
        end
    end

    // PWM counter, optional soft-start ramp, and registered bridge outputs
    always_comb begin
        pwm_cnt_d = pwm_cnt_q + 1'b1;
`ifdef DRIVE_SOFTSTART_EN
        eff_duty_d = eff_duty_q;
        if (state_d == ST_FOLLOW && state_q != ST_FOLLOW) begin
            eff_duty_d = '0;
        end else if (duty < eff_duty_q) begin
            eff_duty_d = duty;
        end else if ((&pwm_cnt_q) && (eff_duty_q < duty)) begin
            eff_duty_d = eff_duty_q + 1'b1;
        end
        duty_cmp = (state_d == ST_FOLLOW) ? eff_duty_d : duty;
`else
        duty_cmp = duty;
`endif
        pwm_on = (&duty_cmp) || (pwm_cnt_q < duty_cmp);

        case (state_d)
            ST_FOLLOW:  motor_in_d = follow_dir;
            ST_REVERSE: motor_in_d = c_DIR_REV;
            ST_TURN:    motor_in_d = c_DIR_STEER_R;
            ST_SEARCH:  motor_in_d = c_DIR_STEER_L;
            default:    motor_in_d = c_DIR_OFF;
        endcase
        motor_en_d = (state_d != ST_STOP && pwm_on) ? 2'b11 : 2'b00;
    end

    // All registers, synchronous active-high reset
    always_ff @(posedge clk) begin
        if (reset) begin
            induct_s1_q <= 3'b111;
            induct_s2_q <= 3'b111;
            proxim_s1_q <= 1'b0;
            proxim_s2_q <= 1'b0;
            fi_q        <= 3'b111;
            fi_cand_q   <= 3'b111;
            fi_cnt_q    <= '0;
            fp_q        <= 1'b0;
            fp_cand_q   <= 1'b0;
            fp_cnt_q    <= '0;
            state_q     <= ST_STOP;
            dwell_q     <= '0;
            lost_cnt_q  <= '0;
            lost_q      <= 1'b0;
            last_dir_q  <= c_DIR_FWD;
            motor_in_q  <= c_DIR_OFF;
            motor_en_q  <= 2'b00;
            pwm_cnt_q   <= '0;
`ifdef DRIVE_SOFTSTART_EN
            eff_duty_q  <= '0;
`endif
        end else begin
            induct_s1_q <= induct_s1_d;
            induct_s2_q <= induct_s2_d;
            proxim_s1_q <= proxim_s1_d;
            proxim_s2_q <= proxim_s2_d;
            fi_q        <= fi_d;
            fi_cand_q   <= fi_cand_d;
            fi_cnt_q    <= fi_cnt_d;
            fp_q        <= fp_d;
            fp_cand_q   <= fp_cand_d;
            fp_cnt_q    <= fp_cnt_d;
            state_q     <= state_d;
            dwell_q     <= dwell_d;
            lost_cnt_q  <= lost_cnt_d;
            lost_q      <= lost_d;
            last_dir_q  <= last_dir_d;
            motor_in_q  <= motor_in_d;
            motor_en_q  <= motor_en_d;
            pwm_cnt_q   <= pwm_cnt_d;
`ifdef DRIVE_SOFTSTART_EN
            eff_duty_q  <= eff_duty_d;
`endif
        end
    end

    assign motorIn = motor_in_q;
    assign motorEn = motor_en_q;
    assign state   = state_q;
    assign lost    = lost_q;

endmodule
`default_nettype wire

// File: doc/rover_drive_sequencer.md
# rover_drive_sequencer

Clocked drive controller for the line-following rover. It sits between the raw inductive-sensor/proximity inputs and the two-motor H-bridge, and sequences the bridge through line following, timed obstacle avoidance, line search and stop. Inputs are synchronised and debounced. Direction and enable outputs are registered, and the enable is gated by a PWM speed generator.

## Interface
- `DEBOUNCE_CYC`, 16: consecutive stable cycles required before a filtered input updates.
- `PWM_BITS`, 8: width of the PWM counter and of `duty`.
- `AVOID_REV_CYC`, 1000: cycles spent in REVERSE.
- `AVOID_TURN_CYC`, 2000: cycles spent in TURN.
- `LOST_CYC`, 5000: consecutive all-off-tape cycles in FOLLOW before entering SEARCH.
- `SEARCH_CYC`, 20000: maximum cycles in SEARCH before STOP.
- `clk`  in  1  single clock; all logic is rising-edge.
- `reset`  in  1  synchronous, active-high.
- `run`  in  1  level enable; low forces STOP.
- `induct`  in  3  inductive sensors, active LOW, bit order left|middle|right.
- `proxim`  in  1  obstacle detected, active high.
- `duty`  in  PWM_BITS  speed command.
- `motorIn`  out  4  H-bridge direction bits.
- `motorEn`  out  2  motor enables, both bits always equal.
- `state`  out  3  current FSM state code.
- `lost`  out  1  sticky flag: SEARCH timed out.

## Operation
- Input path: `induct` and `proxim` each pass through 2 sync flops, then a per-input debounce counter.
  - The filtered value `fi`/`fp` takes the synced value after it has differed from the filtered value for DEBOUNCE_CYC consecutive cycles.
  - Any glitch restarts that input's count.
- Direction codes:
  - FWD = 1001.
  - STEER_L = 0101.
  - STEER_R = 1010.
  - REV = 0110.
  - OFF = 0000.
- Line decode of `fi`:
  - 101 → FWD.
  - 001 or 011 → STEER_L.
  - 100 or 110 → STEER_R.
  - 111 → off-tape.
  - 000 or 010 → ambiguous; hold the last direction.
- States and codes: STOP=0, FOLLOW=1, REVERSE=2, TURN=3, SEARCH=4.
- Transitions (priority: `reset` > `run`=0 > rules below):
  - STOP → FOLLOW when `run`=1 and `lost`=0.
  - FOLLOW → REVERSE when `fp`=1.
  - FOLLOW → SEARCH after LOST_CYC consecutive cycles with `fi`=111. The counter clears on any other pattern.
  - FOLLOW otherwise drives the decoded direction.
  - REVERSE drives REV for exactly AVOID_REV_CYC cycles, then goes to TURN.
  - TURN drives STEER_R for AVOID_TURN_CYC cycles, then goes to FOLLOW if `fi`≠111, else SEARCH.
  - `fp`=1 in TURN or SEARCH → REVERSE, with the dwell timer restarted.
  - `fp` is ignored in REVERSE.
  - SEARCH drives STEER_L (spin). It exits to FOLLOW on the first cycle with `fi`≠111, or goes to STOP with `lost`←1 after SEARCH_CYC cycles.
  - Any state → STOP on `run`=0.
- `lost` clears only on `reset` or on `run`=0.
- One dwell counter is shared by all states and clears on every state entry.
- PWM and enables:
  - Free-running PWM_BITS counter; `pwm_on` = (cnt < duty), except that `duty` = all-ones forces `pwm_on`=1.
  - `duty`=0 gives enables always 00.
  - `motorEn` = {2{`pwm_on`}} in FOLLOW, REVERSE, TURN and SEARCH; 00 in STOP.
- In STOP, `motorIn`=OFF.

## Timing
- Reset values:
  - `state`=0, `motorIn`=0000, `motorEn`=00, `lost`=0.
  - `fi`=111, `fp`=0.
  - Sync flops reset to 111/0. Dwell, lost and PWM counters = 0. Last direction = FWD.
- `motorIn`, `motorEn`, `state` and `lost` are registered and computed from next-state.
- Latency from a raw input change (held stable) to the outputs: the filtered value updates at edge DEBOUNCE_CYC+2, and the outputs change at edge DEBOUNCE_CYC+3.
- `run` is not debounced; outputs reflect `run`=0 at the next edge.
- Dwell exit: a state entered at edge N leaves at edge N+AVOID_*_CYC.
- Simultaneous events:
  - `fp` rising on the same cycle LOST_CYC expires → REVERSE.
  - `run`=0 overrides every other condition.
  - `reset` mid-avoidance → STOP next edge with all counters cleared.
- `duty` is sampled every cycle, no glitch protection required.
- The PWM counter wraps 2^PWM_BITS−1 → 0.

## Configuration
- `DRIVE_SOFTSTART_EN` defined:
  - An effective-duty register resets to 0 on every entry into FOLLOW.
  - It increments by 1 at each PWM counter wrap until it equals `duty`; a lower `duty` is tracked immediately.
  - PWM compares against the effective duty. Other states use `duty` directly.
- Undefined: no ramp; PWM always compares against `duty`.

## Test plan
Parameters: DEBOUNCE_CYC=4, PWM_BITS=4, AVOID_REV_CYC=8, AVOID_TURN_CYC=8, LOST_CYC=16, SEARCH_CYC=32, `duty`=15.
- Reset held 3 cycles then released with `run`=1, `induct`=101 → `state`=1 next edge; `motorIn`=1001 at edge 7 after raw stable; `motorEn`=11.
- `induct` 101→011 stable, then a 2-cycle glitch to 110 → `motorIn`=0101 after 7 edges; glitch ignored.
- `proxim` pulse stable 6 cycles during FOLLOW → `state` 2 with REV for 8 cycles, then 3 with 1010 for 8 cycles, then FOLLOW.
- `induct`=111 held → SEARCH 16 cycles after `fi`=111; still 111 → STOP after 32 more cycles with `lost`=1. `run` 1→0→1 → `lost`=0, FOLLOW.
- `duty`=4 → `motorEn`=11 for 4 of every 16 cycles. `duty`=0 → always 00.
- With `DRIVE_SOFTSTART_EN` and `duty`=3: enables are high 0, 1, 2, 3, 3 cycles in successive PWM periods after FOLLOW entry.
